maze_bfs_solver: RTL and testbench

Parametrised successor to the 15x15 maze solver. Loads an NxN bit maze serially, runs a true FIFO breadth-first search between runtime-selectable start and goal cells, and streams the shortest path start->goal under a valid/ready handshake. Failures are reported as a single maze_not_valid beat: wall at an endpoint, no path, or frontier queue overflow. It sits between the maze loader testbench/stream source and the path consumer.

---
 rtl/maze_bfs_solver.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_maze_bfs_solver.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_bfs_solver.sv
// rtl/maze_bfs_solver.sv - serial-loaded NxN maze solver: FIFO BFS from goal, streams shortest path start->goal
module maze_bfs_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, count;
    logic [AW-1:0] wr_addr;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign wr_addr = clr ? '0 : wr_ptr[AW-1:0];

    // A clear may coincide with the first push, which then lands in slot 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= push ? (AW+1)'(1) : '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && (clr || !full)) mem[wr_addr] <= din;
    end
endmodule

module maze_bfs_solver #(
    parameter int N      = 15,
    parameter int CW     = 4,
    parameter int QDEPTH = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          maze,
    input  logic [CW-1:0] start_x,
    input  logic [CW-1:0] start_y,
    input  logic [CW-1:0] goal_x,
    input  logic [CW-1:0] goal_y,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_x,
    output logic [CW-1:0] out_y,
    output logic          out_last,
    output logic          maze_not_valid
);
    localparam int IW = 2 * CW;
    localparam int NC = N * N;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_INIT, S_POP, S_CHECK, S_TRACE, S_FAIL
    } state_t;

    state_t        state, state_nx;
    logic [NC-1:0] wall_mem;
    logic [NC-1:0] visited;
    logic [1:0]    parent_mem [NC];
    logic [IW-1:0] load_cnt, load_addr;
    logic [CW-1:0] sx, sy, gx, gy;
    logic [CW-1:0] cur_x, cur_y;
    logic [1:0]    dir;

    logic [CW-1:0] nb_x, nb_y, step_x, step_y;
    logic          nb_inb, nb_accept, nb_is_start, nb_take;
    logic [IW-1:0] nb_idx, start_idx, goal_idx, trace_idx;
    logic [1:0]    trace_dir;

    logic          fifo_clr, fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [IW-1:0] fifo_din, fifo_dout;

    function automatic logic [IW-1:0] cell_idx(input logic [CW-1:0] x, input logic [CW-1:0] y);
        return IW'(y) * IW'(N) + IW'(x);
    endfunction

    assign start_idx = cell_idx(sx, sy);
    assign goal_idx  = cell_idx(gx, gy);
    assign load_addr = (state == S_IDLE) ? '0 : load_cnt;
    assign trace_idx = cell_idx(out_x, out_y);
    assign trace_dir = parent_mem[trace_idx];

    // Direction codes: 0 up (y-1), 1 down (y+1), 2 left (x-1), 3 right (x+1).
    // The edge test gates the arithmetic so coordinates never wrap.
    always_comb begin
        nb_x   = cur_x;
        nb_y   = cur_y;
        nb_inb = 1'b0;
        case (dir)
            2'd0: begin
                nb_inb = (cur_y != '0);
                if (nb_inb) nb_y = cur_y - 1'b1;
            end
            2'd1: begin
                nb_inb = (cur_y != CW'(N - 1));
                if (nb_inb) nb_y = cur_y + 1'b1;
            end
            2'd2: begin
                nb_inb = (cur_x != '0);
                if (nb_inb) nb_x = cur_x - 1'b1;
            end
            default: begin
                nb_inb = (cur_x != CW'(N - 1));
                if (nb_inb) nb_x = cur_x + 1'b1;
            end
        endcase
    end

    assign nb_idx      = cell_idx(nb_x, nb_y);
    assign nb_accept   = nb_inb && !wall_mem[nb_idx] && !visited[nb_idx];
    assign nb_is_start = (nb_x == sx) && (nb_y == sy);
    assign nb_take     = (state == S_CHECK) && nb_accept && !fifo_full;

    always_comb begin
        step_x = out_x;
        step_y = out_y;
        case (trace_dir)
            2'd0:    step_y = out_y - 1'b1;
            2'd1:    step_y = out_y + 1'b1;
            2'd2:    step_x = out_x - 1'b1;
            default: step_x = out_x + 1'b1;
        endcase
    end

    maze_bfs_fifo #(.W(IW), .DEPTH(QDEPTH)) u_frontier (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (fifo_clr),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        state_nx  = state;
        fifo_clr  = 1'b0;
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        fifo_din  = {nb_x, nb_y};
        case (state)
            S_IDLE:  if (in_valid) state_nx = S_LOAD;
            S_LOAD:  if (in_valid && load_cnt == IW'(NC - 1)) state_nx = S_INIT;
            S_INIT: begin
                fifo_clr = 1'b1;
                if (wall_mem[start_idx] || wall_mem[goal_idx]) begin
                    state_nx = S_FAIL;
                end else begin
                    fifo_push = 1'b1;
                    fifo_din  = {gx, gy};
                    state_nx  = (start_idx == goal_idx) ? S_TRACE : S_POP;
                end
            end
            S_POP: begin
                if (fifo_empty) begin
                    state_nx = S_FAIL;
                end else begin
                    fifo_pop = 1'b1;
                    state_nx = S_CHECK;
                end
            end
            S_CHECK: begin
                if (nb_accept) begin
                    if (fifo_full) begin
                        state_nx = S_FAIL;
                    end else begin
                        fifo_push = 1'b1;
                        if (nb_is_start)      state_nx = S_TRACE;
                        else if (dir == 2'd3) state_nx = S_POP;
                    end
                end else if (dir == 2'd3) begin
                    state_nx = S_POP;
                end
            end
            S_TRACE: if (out_valid && out_ready && out_last) state_nx = S_IDLE;
            S_FAIL:  if (out_valid && out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            busy           <= 1'b0;
            out_valid      <= 1'b0;
            out_last       <= 1'b0;
            maze_not_valid <= 1'b0;
            out_x          <= '0;
            out_y          <= '0;
            load_cnt       <= '0;
            dir            <= '0;
            cur_x          <= '0;
            cur_y          <= '0;
            sx             <= '0;
            sy             <= '0;
            gx             <= '0;
            gy             <= '0;
            visited        <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        busy     <= 1'b1;
                        load_cnt <= IW'(1);
                        sx       <= start_x;
                        sy       <= start_y;
                        gx       <= goal_x;
                        gy       <= goal_y;
                    end
                end
                S_LOAD: if (in_valid) load_cnt <= load_cnt + 1'b1;
                S_INIT: begin
                    visited           <= '0;
                    visited[goal_idx] <= 1'b1;
                end
                S_POP: begin
                    cur_x <= fifo_dout[IW-1:CW];
                    cur_y <= fifo_dout[CW-1:0];
                    dir   <= '0;
                end
                S_CHECK: begin
                    if (nb_take) visited[nb_idx] <= 1'b1;
                    dir <= dir + 1'b1;
                end
                // The first TRACE/FAIL cycle loads the output register; afterwards it advances per handshake.
                S_TRACE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_x     <= sx;
                        out_y     <= sy;
                        out_last  <= (sx == gx) && (sy == gy);
                    end else if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_x     <= '0;
                            out_y     <= '0;
                            busy      <= 1'b0;
                        end else begin
                            out_x    <= step_x;
                            out_y    <= step_y;
                            out_last <= (step_x == gx) && (step_y == gy);
                        end
                    end
                end
                S_FAIL: begin
                    if (!out_valid) begin
                        out_valid      <= 1'b1;
                        maze_not_valid <= 1'b1;
                        out_last       <= 1'b1;
                        out_x          <= '0;
                        out_y          <= '0;
                    end else if (out_ready) begin
                        out_valid      <= 1'b0;
                        maze_not_valid <= 1'b0;
                        out_last       <= 1'b0;
                        busy           <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Maze and parent storage survive reset; only visited gates their use.
    always_ff @(posedge clk) begin
        if (rst_n && in_valid && (state == S_IDLE || state == S_LOAD))
            wall_mem[load_addr] <= maze;
        if (rst_n && nb_take)
            parent_mem[nb_idx] <= dir ^ 2'b01;
    end
endmodule

// File: tb/tb_maze_bfs_solver.sv
// tb/tb_maze_bfs_solver.sv - scoreboard bench for maze_bfs_solver against a queue-based BFS reference
module tb_maze_bfs_solver;
    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic       last;
        logic       nv;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [2:0]      in_valid, maze_bit, out_ready;
    logic [2:0][3:0] sx, sy, gx, gy;
    logic [2:0]      busy_w, ov_w, ol_w, nv_w;
    logic [2:0][3:0] ox_w, oy_w;

    beat_t exp_q[3][$];
    int    beats_seen[3];
    int    checks = 0;
    int    errors = 0;
    bit    cur_maze[256];

    // dut0: N=15/Q=64, dut1: N=7/Q=4, dut2: N=7/Q=64
    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int GN = (g == 0) ? 15 : 7;
        localparam int GC = (g == 0) ? 4 : 3;
        localparam int GQ = (g == 1) ? 4 : 64;
        logic [GC-1:0] ox, oy;
        beat_t got_b, exp_b, prev_b;
        bit    stalled = 1'b0;

        maze_bfs_solver #(.N(GN), .CW(GC), .QDEPTH(GQ)) u_dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .in_valid       (in_valid[g]),
            .maze           (maze_bit[g]),
            .start_x        (sx[g][GC-1:0]),
            .start_y        (sy[g][GC-1:0]),
            .goal_x         (gx[g][GC-1:0]),
            .goal_y         (gy[g][GC-1:0]),
            .busy           (busy_w[g]),
            .out_valid      (ov_w[g]),
            .out_ready      (out_ready[g]),
            .out_x          (ox),
            .out_y          (oy),
            .out_last       (ol_w[g]),
            .maze_not_valid (nv_w[g])
        );
        assign ox_w[g] = 4'(ox);
        assign oy_w[g] = 4'(oy);

        always @(negedge clk) begin
            got_b.x    = ox_w[g];
            got_b.y    = oy_w[g];
            got_b.last = ol_w[g];
            got_b.nv   = nv_w[g];
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    checks++;
                    if (!ov_w[g] || got_b != prev_b) begin
                        errors++;
                        $display("FAIL hold dut%0d: got valid=%0b x=%0d y=%0d last=%0b nv=%0b, required valid=1 x=%0d y=%0d last=%0b nv=%0b",
                                 g, ov_w[g], got_b.x, got_b.y, got_b.last, got_b.nv, prev_b.x, prev_b.y, prev_b.last, prev_b.nv);
                    end
                end
                stalled = 1'b0;
                if (ov_w[g] && out_ready[g]) begin
                    checks++;
                    beats_seen[g]++;
                    if (exp_q[g].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat dut%0d: got x=%0d y=%0d last=%0b nv=%0b, required no beat",
                                 g, got_b.x, got_b.y, got_b.last, got_b.nv);
                    end else begin
                        exp_b = exp_q[g].pop_front();
                        if (got_b != exp_b) begin
                            errors++;
                            $display("FAIL beat dut%0d #%0d: got x=%0d y=%0d last=%0b nv=%0b, required x=%0d y=%0d last=%0b nv=%0b",
                                     g, beats_seen[g], got_b.x, got_b.y, got_b.last, got_b.nv, exp_b.x, exp_b.y, exp_b.last, exp_b.nv);
                        end
                    end
                end else if (ov_w[g]) begin
                    stalled = 1'b1;
                    prev_b  = got_b;
                end
            end
        end
    end

    function automatic void push_beat(input int k, input int x, input int y, input bit last, input bit nv);
        beat_t b;
        b.x    = 4'(x);
        b.y    = 4'(y);
        b.last = last;
        b.nv   = nv;
        exp_q[k].push_back(b);
    endfunction

    // Reference: plain BFS from goal over cell indices; parent kept as a cell index.
    function automatic void model(input int k, input int n, input int q,
                                  input int sxv, input int syv, input int gxv, input int gyv);
        int par[256];
        bit vis[256];
        int fq[$];
        int s, gl, cur, nb, cx, cy, nx, ny;
        bit found, fail;
        s  = syv * n + sxv;
        gl = gyv * n + gxv;
        if (cur_maze[s] || cur_maze[gl]) begin
            push_beat(k, 0, 0, 1'b1, 1'b1);
            return;
        end
        for (int i = 0; i < 256; i++) vis[i] = 1'b0;
        found = (s == gl);
        fail  = 1'b0;
        vis[gl] = 1'b1;
        fq.push_back(gl);
        while (!found && !fail) begin
            if (fq.size() == 0) begin
                fail = 1'b1;
                break;
            end
            cur = fq.pop_front();
            cx  = cur % n;
            cy  = cur / n;
            for (int d = 0; d < 4 && !found && !fail; d++) begin
                nx = cx;
                ny = cy;
                case (d)
                    0:       ny = cy - 1;
                    1:       ny = cy + 1;
                    2:       nx = cx - 1;
                    default: nx = cx + 1;
                endcase
                if (nx < 0 || ny < 0 || nx >= n || ny >= n) continue;
                nb = ny * n + nx;
                if (cur_maze[nb] || vis[nb]) continue;
                if (fq.size() == q) begin
                    fail = 1'b1;
                    break;
                end
                vis[nb] = 1'b1;
                par[nb] = cur;
                fq.push_back(nb);
                if (nb == s) found = 1'b1;
            end
        end
        if (fail) begin
            push_beat(k, 0, 0, 1'b1, 1'b1);
            return;
        end
        cur = s;
        for (int i = 0; i < 256; i++) begin
            push_beat(k, cur % n, cur / n, cur == gl, 1'b0);
            if (cur == gl) break;
            cur = par[cur];
        end
    endfunction

    function automatic void build_border(input int n);
        for (int i = 0; i < 256; i++) cur_maze[i] = 1'b0;
        for (int y = 0; y < n; y++)
            for (int x = 0; x < n; x++)
                cur_maze[y * n + x] = (x == 0 || y == 0 || x == n - 1 || y == n - 1);
    endfunction

    task automatic load_maze(input int k, input int n, input int sxv, input int syv,
                             input int gxv, input int gyv, input bit gaps);
        sx[k] = 4'(sxv);
        sy[k] = 4'(syv);
        gx[k] = 4'(gxv);
        gy[k] = 4'(gyv);
        for (int i = 0; i < n * n; i++) begin
            if (gaps) begin
                in_valid[k] = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            in_valid[k] = 1'b1;
            maze_bit[k] = cur_maze[i];
            @(posedge clk);
            #1;
            if (i == 0) begin
                sx[k] = 4'($urandom);
                sy[k] = 4'($urandom);
                gx[k] = 4'($urandom);
                gy[k] = 4'($urandom);
            end
        end
        in_valid[k] = 1'b0;
    endtask

    task automatic drain(input int k, input int rmode, output int first_lat);
        int cyc;
        cyc = 0;
        first_lat = -1;
        while ((exp_q[k].size() != 0 || busy_w[k]) && cyc < 20000) begin
            case (rmode)
                0:       out_ready[k] = 1'b1;
                1:       out_ready[k] = ((cyc % 2) == 0);
                default: out_ready[k] = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (ov_w[k] && first_lat < 0) first_lat = cyc;
            @(posedge clk);
            #1;
            cyc++;
        end
        out_ready[k] = 1'b0;
        if (cyc >= 20000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout dut%0d: got %0d cycles with %0d beats pending, required completion", k, cyc, exp_q[k].size());
        end
    endtask

    task automatic run_case(input int k, input int n, input int q, input int sxv, input int syv,
                            input int gxv, input int gyv, input int rmode, input bit gaps,
                            input int exp_beats, input int max_lat, input string name);
        int first_lat, want;
        exp_q[k].delete();
        model(k, n, q, sxv, syv, gxv, gyv);
        want = (exp_beats >= 0) ? exp_beats : exp_q[k].size();
        beats_seen[k] = 0;
        load_maze(k, n, sxv, syv, gxv, gyv, gaps);
        drain(k, rmode, first_lat);
        checks++;
        if (first_lat < 0) begin
            errors++;
            $display("FAIL %s no_output: got no out_valid, required at least one beat", name);
        end
        if (max_lat > 0) begin
            checks++;
            if (first_lat < 0 || first_lat > max_lat) begin
                errors++;
                $display("FAIL %s latency: got %0d cycles, required <= %0d", name, first_lat, max_lat);
            end
        end
        checks++;
        if (beats_seen[k] != want) begin
            errors++;
            $display("FAIL %s beat_count: got %0d, required %0d", name, beats_seen[k], want);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc, sxr, syr, gxr, gyr, n;
        rst_n     = 1'b0;
        in_valid  = '0;
        maze_bit  = '0;
        out_ready = '0;
        sx = '0; sy = '0; gx = '0; gy = '0;
        for (int k = 0; k < 3; k++) beats_seen[k] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (busy_w[k] || ov_w[k] || ol_w[k] || nv_w[k] || ox_w[k] != 0 || oy_w[k] != 0) begin
                errors++;
                $display("FAIL reset dut%0d: got busy=%0b valid=%0b last=%0b nv=%0b x=%0d y=%0d, required all 0",
                         k, busy_w[k], ov_w[k], ol_w[k], nv_w[k], ox_w[k], oy_w[k]);
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        build_border(15);
        run_case(0, 15, 64, 1, 1, 13, 13, 0, 1'b1, 25, 0, "open15");

        build_border(15);
        for (int x = 0; x < 15; x++) cur_maze[7 * 15 + x] = 1'b1;
        run_case(0, 15, 64, 1, 1, 13, 13, 0, 1'b1, 1, 0, "row7_wall");

        build_border(15);
        cur_maze[1 * 15 + 1] = 1'b1;
        run_case(0, 15, 64, 1, 1, 13, 13, 0, 1'b0, 1, 3, "start_wall");

        build_border(15);
        for (int y = 2; y <= 12; y += 2)
            for (int x = 1; x <= 13; x++)
                cur_maze[y * 15 + x] = (x != (((y / 2) % 2 == 1) ? 13 : 1));
        run_case(0, 15, 64, 1, 1, 13, 13, 0, 1'b1, -1, 0, "serpentine_ready");
        run_case(0, 15, 64, 1, 1, 13, 13, 1, 1'b1, -1, 0, "serpentine_toggle");

        build_border(7);
        run_case(1, 7, 4, 1, 1, 5, 5, 0, 1'b1, 1, 0, "overflow_q4");
        run_case(2, 7, 64, 1, 1, 5, 5, 2, 1'b1, 9, 0, "open7_q64");

        for (int t = 0; t < 9; t++) begin
            int k;
            k = t % 3;
            n = (k == 0) ? 15 : 7;
            for (int i = 0; i < 256; i++) cur_maze[i] = ($urandom_range(0, 3) == 0);
            sxr = $urandom_range(0, n - 1);
            syr = $urandom_range(0, n - 1);
            gxr = $urandom_range(0, n - 1);
            gyr = $urandom_range(0, n - 1);
            if ($urandom_range(0, 4) != 0) begin
                cur_maze[syr * n + sxr] = 1'b0;
                cur_maze[gyr * n + gxr] = 1'b0;
            end
            run_case(k, n, (k == 1) ? 4 : 64, sxr, syr, gxr, gyr, 2, 1'b1, -1, 0, "random");
        end

        build_border(15);
        exp_q[0].delete();
        model(0, 15, 64, 1, 1, 13, 13);
        beats_seen[0] = 0;
        load_maze(0, 15, 1, 1, 13, 13, 1'b0);
        cyc = 0;
        while (beats_seen[0] < 5 && cyc < 5000) begin
            out_ready[0] = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (beats_seen[0] < 5) begin
            errors++;
            $display("FAIL pre_reset_beats: got %0d beats, required >= 5", beats_seen[0]);
        end
        rst_n = 1'b0;
        out_ready[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy_w[0] || ov_w[0] || ol_w[0] || nv_w[0]) begin
            errors++;
            $display("FAIL mid_trace_reset: got busy=%0b valid=%0b last=%0b nv=%0b, required all 0",
                     busy_w[0], ov_w[0], ol_w[0], nv_w[0]);
        end
        exp_q[0].delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        build_border(15);
        run_case(0, 15, 64, 3, 3, 3, 3, 0, 1'b0, 1, 0, "reset_then_single");
        out_ready = '1;
        repeat (20) @(posedge clk);
        #1;
        out_ready = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
